// File: rtl/qspi_arb_pkg.sv
// Shared types and default widths for the QSPI channel arbiter.
// The watchdog option is controlled by QSPI_ARB_TIMEOUT_EN in qspi_chan_arbiter.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_BUSY = 2'd2
  } arb_state_t;

  localparam int QSPI_INST_W = 8;
  localparam int QSPI_ADDR_W = 24;
  localparam int QSPI_DATA_W = 32;

endpackage

// File: rtl/qspi_chan_arbiter_if.sv
// Downstream request/FIFO bundle between the channel arbiter and the transfer level.
// The master side is the arbiter; the slave side is the control/transfer logic.
interface qspi_chan_arbiter_if
  import qspi_arb_pkg::*;
#(
  parameter int ADDR_W = QSPI_ADDR_W,
  parameter int DATA_W = QSPI_DATA_W,
  parameter int CH_W   = 1
);

  logic                   io_req_valid;
  logic                   io_req_ready;
  logic [QSPI_INST_W-1:0] io_req_inst;
  logic [ADDR_W-1:0]      io_req_addr;
  logic [7:0]             io_req_data_size;
  logic [7:0]             io_req_data_burstlen;
  logic [CH_W-1:0]        io_req_ch_id;
  logic                   io_tdata_fifo_wen;
  logic [DATA_W-1:0]      io_tdata_fifo_wdata;
  logic                   io_tdata_fifo_full;
  logic                   io_rdata_fifo_ren;
  logic [DATA_W-1:0]      io_rdata_fifo_rdata;
  logic                   io_rdata_fifo_empty;
  logic                   io_xfer_done;

  modport master (
    output io_req_valid, io_req_inst, io_req_addr, io_req_data_size,
           io_req_data_burstlen, io_req_ch_id, io_tdata_fifo_wen,
           io_tdata_fifo_wdata, io_rdata_fifo_ren,
    input  io_req_ready, io_tdata_fifo_full, io_rdata_fifo_rdata,
           io_rdata_fifo_empty, io_xfer_done
  );

  modport slave (
    input  io_req_valid, io_req_inst, io_req_addr, io_req_data_size,
           io_req_data_burstlen, io_req_ch_id, io_tdata_fifo_wen,
           io_tdata_fifo_wdata, io_rdata_fifo_ren,
    output io_req_ready, io_tdata_fifo_full, io_rdata_fifo_rdata,
           io_rdata_fifo_empty, io_xfer_done
  );

endinterface

// File: rtl/qspi_rr_picker.sv
// Rotating priority encoder: first set request bit searching upward from ptr+1,
// wrapping modulo NUM_CH, returned both one-hot and as an index.
module qspi_rr_picker #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   idx,
  output logic              any_req
);

  int   cand;
  logic found;

  // The last channel visited (k == NUM_CH) is ptr itself, so it has lowest priority.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = (int'(ptr) + k) % NUM_CH;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = CH_W'(cand);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/qspi_chan_arbiter.sv
// N-channel round-robin arbiter that locks one channel onto the QSPI request and FIFO path
// for a whole flash transaction. Define QSPI_ARB_TIMEOUT_EN to build the abort watchdog.
module qspi_chan_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int CH_W    = 1,
  parameter int ADDR_W  = QSPI_ADDR_W,
  parameter int DATA_W  = QSPI_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [NUM_CH-1:0]             io_ch_req_valid,
  output logic [NUM_CH-1:0]             io_ch_req_ready,
  input  logic [NUM_CH*QSPI_INST_W-1:0] io_ch_req_inst,
  input  logic [NUM_CH*ADDR_W-1:0]      io_ch_req_addr,
  input  logic [NUM_CH*8-1:0]           io_ch_req_data_size,
  input  logic [NUM_CH*8-1:0]           io_ch_req_data_burstlen,
  input  logic [NUM_CH-1:0]             io_ch_tdata_wen,
  input  logic [NUM_CH*DATA_W-1:0]      io_ch_tdata_wdata,
  output logic [NUM_CH-1:0]             io_ch_tdata_full,
  input  logic [NUM_CH-1:0]             io_ch_rdata_ren,
  output logic [DATA_W-1:0]             io_ch_rdata_rdata,
  output logic [NUM_CH-1:0]             io_ch_rdata_empty,
  qspi_chan_arbiter_if.master           dn,
  output logic [NUM_CH-1:0]             io_grant,
  output logic                          io_busy,
  output logic                          io_timeout_err
);

  arb_state_t             state, state_nxt;
  logic [CH_W-1:0]        rr_ptr, owner;
  logic [NUM_CH-1:0]      pick_grant;
  logic [CH_W-1:0]        pick_idx;
  logic                   pick_any;
  logic [QSPI_INST_W-1:0] inst_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [7:0]             size_q, burst_q;
  logic                   owned, release_owner, timeout_hit;
  logic                   tx_wen, rx_ren;
  logic [DATA_W-1:0]      tx_wdata, rx_rdata_bc;

  qspi_rr_picker #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_picker (
    .req     (io_ch_req_valid),
    .ptr     (rr_ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Counter sits at zero while idle, so it reads 0 in the first REQ cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= timeout_hit;
      if (state == ARB_IDLE) wd_cnt <= '0;
      else                   wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state != ARB_IDLE) && (wd_cnt == CNT_W'(TIMEOUT - 1))
                       && !(state == ARB_BUSY && dn.io_xfer_done);
  assign io_timeout_err = err_q;
`else
  assign timeout_hit    = 1'b0;
  assign io_timeout_err = 1'b0;
`endif

  assign owned         = (state != ARB_IDLE);
  assign release_owner = (state == ARB_BUSY && dn.io_xfer_done) || timeout_hit;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Done is only honoured in BUSY; a watchdog abort overrides any state.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_any) state_nxt = ARB_REQ;
      ARB_REQ:  if (dn.io_req_ready) state_nxt = ARB_BUSY;
      ARB_BUSY: if (dn.io_xfer_done) state_nxt = ARB_IDLE;
      default:  state_nxt = ARB_IDLE;
    endcase
    if (timeout_hit) state_nxt = ARB_IDLE;
  end

  // Request fields are captured from the winner in the grant cycle and held until release.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= CH_W'(NUM_CH - 1);
      owner   <= '0;
      inst_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      if (state == ARB_IDLE && pick_any) begin
        owner   <= pick_idx;
        inst_q  <= io_ch_req_inst[pick_idx*QSPI_INST_W +: QSPI_INST_W];
        addr_q  <= io_ch_req_addr[pick_idx*ADDR_W +: ADDR_W];
        size_q  <= io_ch_req_data_size[pick_idx*8 +: 8];
        burst_q <= io_ch_req_data_burstlen[pick_idx*8 +: 8];
      end
      if (release_owner) rr_ptr <= owner;
    end
  end

  always_comb begin
    io_ch_req_ready   = '0;
    io_grant          = '0;
    io_ch_tdata_full  = '1;
    io_ch_rdata_empty = '1;
    tx_wen            = 1'b0;
    tx_wdata          = '0;
    rx_ren            = 1'b0;
    rx_rdata_bc       = '0;
    if (state == ARB_IDLE) io_ch_req_ready = pick_grant;
    if (owned) begin
      io_grant[owner]          = 1'b1;
      io_ch_tdata_full[owner]  = dn.io_tdata_fifo_full;
      io_ch_rdata_empty[owner] = dn.io_rdata_fifo_empty;
      tx_wen                   = io_ch_tdata_wen[owner];
      tx_wdata                 = io_ch_tdata_wdata[owner*DATA_W +: DATA_W];
      rx_ren                   = io_ch_rdata_ren[owner] & ~dn.io_rdata_fifo_empty;
      rx_rdata_bc              = dn.io_rdata_fifo_rdata;
    end
  end

  assign dn.io_req_valid         = (state == ARB_REQ);
  assign dn.io_req_inst          = inst_q;
  assign dn.io_req_addr          = addr_q;
  assign dn.io_req_data_size     = size_q;
  assign dn.io_req_data_burstlen = burst_q;
  assign dn.io_req_ch_id         = owner;
  assign dn.io_tdata_fifo_wen    = tx_wen;
  assign dn.io_tdata_fifo_wdata  = tx_wdata;
  assign dn.io_rdata_fifo_ren    = rx_ren;
  assign io_ch_rdata_rdata       = rx_rdata_bc;
  assign io_busy                 = owned;

endmodule

// File: tb/tb_qspi_chan_arbiter.sv
// Directed bench for qspi_chan_arbiter with four channels; the watchdog expectations
// follow QSPI_ARB_TIMEOUT_EN (TIMEOUT=16 when enabled).
module tb_qspi_chan_arbiter;
  import qspi_arb_pkg::*;

  localparam int NUM_CH  = 4;
  localparam int CH_W    = 2;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
`ifdef QSPI_ARB_TIMEOUT_EN
  localparam logic TO_EN = 1'b1;
`else
  localparam logic TO_EN = 1'b0;
`endif

  logic                     clock;
  logic                     rst_n;
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH*8-1:0]      ch_req_inst;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH*8-1:0]      ch_req_size;
  logic [NUM_CH*8-1:0]      ch_req_burst;
  logic [NUM_CH-1:0]        ch_tdata_wen;
  logic [NUM_CH*DATA_W-1:0] ch_tdata_wdata;
  logic [NUM_CH-1:0]        ch_tdata_full;
  logic [NUM_CH-1:0]        ch_rdata_ren;
  logic [DATA_W-1:0]        ch_rdata_rdata;
  logic [NUM_CH-1:0]        ch_rdata_empty;
  logic [NUM_CH-1:0]        grant;
  logic                     busy;
  logic                     timeout_err;

  int total;
  int bad;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  qspi_chan_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CH_W(CH_W)) dn_if ();

  qspi_chan_arbiter #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock                   (clock),
    .rst_n                   (rst_n),
    .io_ch_req_valid         (ch_req_valid),
    .io_ch_req_ready         (ch_req_ready),
    .io_ch_req_inst          (ch_req_inst),
    .io_ch_req_addr          (ch_req_addr),
    .io_ch_req_data_size     (ch_req_size),
    .io_ch_req_data_burstlen (ch_req_burst),
    .io_ch_tdata_wen         (ch_tdata_wen),
    .io_ch_tdata_wdata       (ch_tdata_wdata),
    .io_ch_tdata_full        (ch_tdata_full),
    .io_ch_rdata_ren         (ch_rdata_ren),
    .io_ch_rdata_rdata       (ch_rdata_rdata),
    .io_ch_rdata_empty       (ch_rdata_empty),
    .dn                      (dn_if),
    .io_grant                (grant),
    .io_busy                 (busy),
    .io_timeout_err          (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int ch, input logic valid, input logic [7:0] inst,
                               input logic [23:0] addr);
    ch_req_valid[ch]             = valid;
    ch_req_inst[ch*8 +: 8]       = inst;
    ch_req_addr[ch*ADDR_W +: 24] = addr;
    ch_req_size[ch*8 +: 8]       = 8'h04;
    ch_req_burst[ch*8 +: 8]      = 8'h01;
  endtask

  initial begin
    logic [3:0] exp_grant;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ch_req_valid = '0; ch_req_inst = '0; ch_req_addr = '0;
    ch_req_size = '0; ch_req_burst = '0;
    ch_tdata_wen = '0; ch_tdata_wdata = '0; ch_rdata_ren = '0;
    dn_if.io_req_ready        = 1'b0;
    dn_if.io_tdata_fifo_full  = 1'b0;
    dn_if.io_rdata_fifo_rdata = 32'h12345678;
    dn_if.io_rdata_fifo_empty = 1'b0;
    dn_if.io_xfer_done        = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_req_valid", 64'(dn_if.io_req_valid), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_grant", 64'(grant), 64'd0);
    checkOutput("rst_full", 64'(ch_tdata_full), 64'hF);
    checkOutput("rst_empty", 64'(ch_rdata_empty), 64'hF);
    checkOutput("rst_timeout", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;

    // Single request on ch0, one-cycle latency to io_req_valid
    @(negedge clock);
    applyStimulus(0, 1'b1, 8'h6B, 24'h001000);
    #1;
    checkOutput("t1_ch_ready", 64'(ch_req_ready), 64'h1);
    @(negedge clock);
    checkOutput("t1_req_valid", 64'(dn_if.io_req_valid), 64'd1);
    checkOutput("t1_inst", 64'(dn_if.io_req_inst), 64'h6B);
    checkOutput("t1_addr", 64'(dn_if.io_req_addr), 64'h001000);
    checkOutput("t1_size", 64'(dn_if.io_req_data_size), 64'h04);
    checkOutput("t1_ch_id", 64'(dn_if.io_req_ch_id), 64'd0);
    checkOutput("t1_grant", 64'(grant), 64'h1);
    checkOutput("t1_ch_ready_req", 64'(ch_req_ready), 64'h0);
    applyStimulus(0, 1'b0, 8'h00, 24'h000000);

    // Ready held low; a done pulse while in REQ must be ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      dn_if.io_xfer_done = (i == 2);
      checkOutput("t4_hold_valid", 64'(dn_if.io_req_valid), 64'd1);
      checkOutput("t4_hold_inst", 64'(dn_if.io_req_inst), 64'h6B);
      checkOutput("t4_hold_addr", 64'(dn_if.io_req_addr), 64'h001000);
    end
    @(negedge clock);
    checkOutput("t4_after_done_valid", 64'(dn_if.io_req_valid), 64'd1);
    dn_if.io_req_ready = 1'b1;
    @(negedge clock);
    dn_if.io_req_ready = 1'b0;
    checkOutput("t4_busy_valid", 64'(dn_if.io_req_valid), 64'd0);
    checkOutput("t4_busy", 64'(busy), 64'd1);
    checkOutput("t4_busy_grant", 64'(grant), 64'h1);
    dn_if.io_xfer_done = 1'b1;
    @(negedge clock);
    dn_if.io_xfer_done = 1'b0;
    checkOutput("t4_done_busy", 64'(busy), 64'd0);
    checkOutput("t4_done_grant", 64'(grant), 64'h0);

    // ch1 owns the path; ch0 traffic must be blocked
    applyStimulus(1, 1'b1, 8'h03, 24'h00ABCD);
    @(negedge clock);
    checkOutput("t3_ch_id", 64'(dn_if.io_req_ch_id), 64'd1);
    checkOutput("t3_grant", 64'(grant), 64'h2);
    applyStimulus(1, 1'b0, 8'h00, 24'h000000);
    dn_if.io_req_ready = 1'b1;
    @(negedge clock);
    dn_if.io_req_ready = 1'b0;
    ch_tdata_wen = 4'b0001;
    ch_tdata_wdata[31:0] = 32'hDEADBEEF;
    #1;
    checkOutput("t3_wen_blocked", 64'(dn_if.io_tdata_fifo_wen), 64'd0);
    checkOutput("t3_full_view", 64'(ch_tdata_full), 64'hD);
    ch_tdata_wen = 4'b0010;
    ch_tdata_wdata[63:32] = 32'hCAFEF00D;
    #1;
    checkOutput("t3_wen_pass", 64'(dn_if.io_tdata_fifo_wen), 64'd1);
    checkOutput("t3_wdata", 64'(dn_if.io_tdata_fifo_wdata), 64'hCAFEF00D);
    dn_if.io_tdata_fifo_full = 1'b1;
    #1;
    checkOutput("t3_full_owner", 64'(ch_tdata_full), 64'hF);
    ch_rdata_ren = 4'b0001;
    #1;
    checkOutput("t3_ren_blocked", 64'(dn_if.io_rdata_fifo_ren), 64'd0);
    ch_rdata_ren = 4'b0010;
    #1;
    checkOutput("t3_ren_pass", 64'(dn_if.io_rdata_fifo_ren), 64'd1);
    checkOutput("t3_empty_view", 64'(ch_rdata_empty), 64'hD);
    checkOutput("t3_rdata", 64'(ch_rdata_rdata), 64'h12345678);
    dn_if.io_rdata_fifo_empty = 1'b1;
    #1;
    checkOutput("t3_ren_empty", 64'(dn_if.io_rdata_fifo_ren), 64'd0);
    checkOutput("t3_empty_owner", 64'(ch_rdata_empty), 64'hF);
    dn_if.io_rdata_fifo_empty = 1'b0;
    dn_if.io_tdata_fifo_full  = 1'b0;

    // Asynchronous reset in BUSY drops ownership immediately
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_grant", 64'(grant), 64'h0);
    checkOutput("t5_busy", 64'(busy), 64'd0);
    checkOutput("t5_full", 64'(ch_tdata_full), 64'hF);
    checkOutput("t5_empty", 64'(ch_rdata_empty), 64'hF);
    checkOutput("t5_wen", 64'(dn_if.io_tdata_fifo_wen), 64'd0);
    checkOutput("t5_ren", 64'(dn_if.io_rdata_fifo_ren), 64'd0);
    ch_tdata_wen = '0;
    ch_rdata_ren = '0;
    @(negedge clock);
    rst_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) applyStimulus(c, 1'b1, 8'(8'h10 + c), 24'(24'h100 * c));

    // All channels valid: grant order 0,1,2,3,0 with done 10 cycles after handshake
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      exp_grant = 4'(1 << exp_order[i]);
      checkOutput("rr_ch_id", 64'(dn_if.io_req_ch_id), 64'(exp_order[i]));
      checkOutput("rr_grant", 64'(grant), 64'(exp_grant));
      checkOutput("rr_inst", 64'(dn_if.io_req_inst), 64'(8'h10 + exp_order[i]));
      dn_if.io_req_ready = 1'b1;
      @(negedge clock);
      dn_if.io_req_ready = 1'b0;
      checkOutput("rr_busy_valid", 64'(dn_if.io_req_valid), 64'd0);
      repeat (9) @(negedge clock);
      dn_if.io_xfer_done = 1'b1;
      @(negedge clock);
      dn_if.io_xfer_done = 1'b0;
      checkOutput("rr_gap_busy", 64'(busy), 64'd0);
      if (i == 4) ch_req_valid = '0;
    end

    // Watchdog: owner ch0 never finishes while ch1 waits
    @(negedge clock);
    applyStimulus(0, 1'b1, 8'hEB, 24'h0F0000);
    @(negedge clock);
    checkOutput("t6_ch_id", 64'(dn_if.io_req_ch_id), 64'd0);
    applyStimulus(0, 1'b0, 8'h00, 24'h000000);
    dn_if.io_req_ready = 1'b1;
    @(negedge clock);
    dn_if.io_req_ready = 1'b0;
    applyStimulus(1, 1'b1, 8'h3B, 24'h000200);
    repeat (14) @(negedge clock);
    checkOutput("t6_pre_err", 64'(timeout_err), 64'd0);
    @(negedge clock);
    checkOutput("t6_err", 64'(timeout_err), 64'(TO_EN));
    checkOutput("t6_err_busy", 64'(busy), 64'(!TO_EN));
    @(negedge clock);
    checkOutput("t6_err_pulse", 64'(timeout_err), 64'd0);
    checkOutput("t6_next_ch_id", 64'(dn_if.io_req_ch_id), 64'(TO_EN));
    checkOutput("t6_next_valid", 64'(dn_if.io_req_valid), 64'(TO_EN));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_chan_arbiter.md
Name: qspi_chan_arbiter

Overview:
- Parametrised N-channel request arbiter that merges NUM_CH requester channels onto the single buf-request / tdata / rdata path toward the QSPI transfer level.
- Generalises the fixed two-channel (dchan/cchan) arrangement to any channel count.
- Adds round-robin fairness, grant locking for a whole flash transaction, and per-channel FIFO routing.
- Sits between the interface level and the control/transfer levels.

Parameters:
NUM_CH, 2, number of requester channels (2..8)
CH_W, 1, channel-id width, ceil(log2(NUM_CH)) and at least 1
ADDR_W, 24, flash address width
DATA_W, 32, FIFO data width
TIMEOUT, 4096, watchdog limit in cycles (used only with the optional feature)

Ports:
- Clock and reset:
clock  input  1  system clock
rst_n  input  1  asynchronous active-low reset
- Channel side (field i occupies slice [i*W +: W]):
io_ch_req_valid  input  NUM_CH  per-channel request valid
io_ch_req_ready  output  NUM_CH  per-channel request accepted (one-cycle pulse)
io_ch_req_inst  input  NUM_CH*8  flash instruction
io_ch_req_addr  input  NUM_CH*ADDR_W  flash address
io_ch_req_data_size  input  NUM_CH*8  data size
io_ch_req_data_burstlen  input  NUM_CH*8  burst length
io_ch_tdata_wen  input  NUM_CH  tx FIFO write enable
io_ch_tdata_wdata  input  NUM_CH*DATA_W  tx FIFO write data
io_ch_tdata_full  output  NUM_CH  tx FIFO full as seen by each channel
io_ch_rdata_ren  input  NUM_CH  rx FIFO read enable
io_ch_rdata_rdata  output  DATA_W  rx FIFO data, broadcast to all channels
io_ch_rdata_empty  output  NUM_CH  rx FIFO empty as seen by each channel
- Downstream side:
io_req_valid  output  1  merged request valid
io_req_ready  input  1  downstream accepts request
io_req_inst  output  8  registered instruction
io_req_addr  output  ADDR_W  registered address
io_req_data_size  output  8  registered data size
io_req_data_burstlen  output  8  registered burst length
io_req_ch_id  output  CH_W  owning channel index
io_tdata_fifo_wen  output  1  tx FIFO write enable
io_tdata_fifo_wdata  output  DATA_W  tx FIFO write data
io_tdata_fifo_full  input  1  tx FIFO full
io_rdata_fifo_ren  output  1  rx FIFO read enable
io_rdata_fifo_rdata  input  DATA_W  rx FIFO data
io_rdata_fifo_empty  input  1  rx FIFO empty
io_xfer_done  input  1  one-cycle pulse at end of flash transaction
- Status:
io_grant  output  NUM_CH  one-hot owner, 0 when idle
io_busy  output  1  arbiter not IDLE
io_timeout_err  output  1  watchdog abort pulse; tied 0 when the feature is out

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state=IDLE; rr_ptr=NUM_CH-1, so channel 0 has first priority.
  - All outputs 0, except io_ch_tdata_full and io_ch_rdata_empty, which reset to all-ones.
- FSM states: IDLE, REQ, BUSY.
- IDLE:
  - If any io_ch_req_valid is set, the winner is the first set bit searching upward from rr_ptr+1 modulo NUM_CH.
  - Same cycle: pulse io_ch_req_ready[winner]; register inst/addr/size/burstlen/ch_id; set io_grant; go to REQ.
  - Latency from channel valid to io_req_valid is exactly 1 cycle.
- REQ:
  - io_req_valid=1 and the registered fields stay stable until io_req_ready.
  - On io_req_valid & io_req_ready, go to BUSY.
  - io_xfer_done is ignored in REQ.
- BUSY:
  - io_req_valid=0.
  - On io_xfer_done, set rr_ptr=owner, clear io_grant, return to IDLE.
  - New requests are evaluated in IDLE the following cycle; there is no back-to-back grant in the done cycle.
- FIFO routing (combinational, states REQ and BUSY):
  - io_tdata_fifo_wen = io_ch_tdata_wen[owner]; wdata comes from the owner slice.
  - io_rdata_fifo_ren = io_ch_rdata_ren[owner] & ~io_rdata_fifo_empty.
  - Owner sees the real full/empty. Non-owners see full=1 and empty=1; their wen/ren are ignored.
  - In IDLE all channels see full=1 and empty=1.
- Simultaneous requests are resolved by round-robin only. A channel whose valid drops before grant is simply not chosen.
- Reset asserted mid-transaction returns the FSM to IDLE immediately and drops all routing.

Optional Feature:
- Macro: QSPI_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or BUSY.
  - On reaching TIMEOUT-1 without io_xfer_done: pulse io_timeout_err for 1 cycle, force IDLE, advance rr_ptr to the owner.
- When undefined: no counter is built, io_timeout_err is tied 0, and the arbiter waits for done indefinitely.

Decomposition:
- Shared package qspi_arb_pkg holds:
  - FSM state encoding (ARB_IDLE=2'd0, ARB_REQ=2'd1, ARB_BUSY=2'd2);
  - default widths (QSPI_INST_W=8, QSPI_ADDR_W=24, QSPI_DATA_W=32).
- One sub-module, qspi_rr_picker: combinational rotate-priority-encoder with inputs req vector and ptr, outputs one-hot grant and index.

Test Plan:
1. Reset, then ch0 valid with inst=0x6B, addr=0x001000 -> io_ch_req_ready[0] pulses in the valid cycle; next cycle io_req_valid=1, io_req_inst=0x6B, io_req_ch_id=0.
2. NUM_CH=4, all valid continuously, done 10 cycles after each handshake -> grant order 0,1,2,3,0.
3. Owner ch1 in BUSY, ch0 drives tdata_wen with 0xDEADBEEF -> io_tdata_fifo_wen stays 0; ch1 write of 0xCAFEF00D passes through; io_ch_tdata_full[0]=1.
4. io_req_ready held low 5 cycles -> io_req_valid and fields stable; io_xfer_done pulsed in REQ -> ignored, state stays REQ.
5. rst_n driven low during BUSY -> same-cycle io_grant=0, io_busy=0, and all full/empty read 1.
6. With QSPI_ARB_TIMEOUT_EN and TIMEOUT=16, no done -> io_timeout_err pulses 16 cycles after REQ entry; a pending ch1 request is granted next.
